// File: rtl/registrador_universal.sv
// Universal shift register (hold/up/down/load) with an automatic load-and-shift burst FSM; 1-cycle update latency.
// Backpressure: en=0 freezes register, counter and FSM, except that DONE always returns to IDLE.
module registrador_universal #(
    parameter int WIDTH  = 7,
    parameter int ROTATE = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [1:0]                     ch,
    input  logic                           d,
    input  logic                           d_esq,
    input  logic [WIDTH-1:0]               bits,
    input  logic                           start,
    input  logic [$clog2(WIDTH+1)-1:0]     n_shifts,
    output logic [WIDTH-1:0]               saidas_registrador,
    output logic                           saida_ultimoflip,
    output logic                           saida_primeiroflip,
    output logic                           busy,
    output logic                           done
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] WMAX = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] shift_up;
    logic [WIDTH-1:0] shift_dn;
    logic [CW-1:0]    load_cnt;

    // In rotate mode the serial inputs are replaced by the bit leaving the opposite end.
    always_comb begin
        shift_up = {q[WIDTH-2:0], (ROTATE != 0) ? q[WIDTH-1] : d};
        shift_dn = {(ROTATE != 0) ? q[0] : d_esq, q[WIDTH-1:1]};
        load_cnt = (n_shifts > WMAX) ? WMAX : n_shifts;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        if (start) begin
                            q    <= bits;
                            cnt  <= load_cnt;
                            busy <= 1'b1;
                            if (load_cnt == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= SHIFT;
                            end
                        end else begin
                            case (ch)
                                2'b01:   q <= shift_up;
                                2'b10:   q <= shift_dn;
                                2'b11:   q <= bits;
                                default: q <= q;
                            endcase
                        end
                    end
                end
                SHIFT: begin
                    if (en) begin
                        q   <= shift_up;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign saidas_registrador = q;
    assign saida_ultimoflip   = q[WIDTH-1];
    assign saida_primeiroflip = q[0];

endmodule

// File: tb/tb_registrador_universal.sv
// Directed bench: four instances (7/16 bits, plain/rotate) driven in lockstep from shared inputs.
// Each scenario task checks its own expected values inline.
module tb_registrador_universal;

    logic        clk = 1'b0;
    logic        rst_n, en, d, d_esq, start;
    logic [1:0]  ch;
    logic [15:0] bits;
    logic [4:0]  n_shifts;

    logic [6:0]  q7a, q7b;
    logic [15:0] q16a, q16b;
    logic [3:0]  uf, pf, bsy, dn;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    registrador_universal #(.WIDTH(7), .ROTATE(0)) u7a (
        .clk(clk), .rst_n(rst_n), .en(en), .ch(ch), .d(d), .d_esq(d_esq),
        .bits(bits[6:0]), .start(start), .n_shifts(n_shifts[2:0]),
        .saidas_registrador(q7a), .saida_ultimoflip(uf[0]), .saida_primeiroflip(pf[0]),
        .busy(bsy[0]), .done(dn[0]));

    registrador_universal #(.WIDTH(7), .ROTATE(1)) u7b (
        .clk(clk), .rst_n(rst_n), .en(en), .ch(ch), .d(d), .d_esq(d_esq),
        .bits(bits[6:0]), .start(start), .n_shifts(n_shifts[2:0]),
        .saidas_registrador(q7b), .saida_ultimoflip(uf[1]), .saida_primeiroflip(pf[1]),
        .busy(bsy[1]), .done(dn[1]));

    registrador_universal #(.WIDTH(16), .ROTATE(0)) u16a (
        .clk(clk), .rst_n(rst_n), .en(en), .ch(ch), .d(d), .d_esq(d_esq),
        .bits(bits), .start(start), .n_shifts(n_shifts),
        .saidas_registrador(q16a), .saida_ultimoflip(uf[2]), .saida_primeiroflip(pf[2]),
        .busy(bsy[2]), .done(dn[2]));

    registrador_universal #(.WIDTH(16), .ROTATE(1)) u16b (
        .clk(clk), .rst_n(rst_n), .en(en), .ch(ch), .d(d), .d_esq(d_esq),
        .bits(bits), .start(start), .n_shifts(n_shifts),
        .saidas_registrador(q16b), .saida_ultimoflip(uf[3]), .saida_primeiroflip(pf[3]),
        .busy(bsy[3]), .done(dn[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; start = 1'b1; ch = 2'b11; bits = 16'hFFFF;
        d = 1'b1; d_esq = 1'b1; n_shifts = 5'd3;
        tick();
        vec++; if ({q7a, q7b} !== 14'h0) begin errs++; $display("FAIL reset_q7: got %h/%h want 00/00", q7a, q7b); end
        vec++; if ({q16a, q16b} !== 32'h0) begin errs++; $display("FAIL reset_q16: got %h/%h want 0000/0000", q16a, q16b); end
        vec++; if ({bsy, dn} !== 8'h00) begin errs++; $display("FAIL reset_flags: busy %b done %b want 0000/0000", bsy, dn); end
        tick();
        vec++; if ({q16a, bsy} !== 20'h0) begin errs++; $display("FAIL reset_held: q16 %h busy %b want 0000/0000", q16a, bsy); end
        rst_n = 1'b1; start = 1'b0; ch = 2'b00; d = 1'b0; d_esq = 1'b0;
    endtask

    task automatic test_manual();
        ch = 2'b11; bits = 16'h0053;
        tick();
        vec++; if (q7a !== 7'h53) begin errs++; $display("FAIL load_w7: got %h want 53", q7a); end
        vec++; if (q16a !== 16'h0053) begin errs++; $display("FAIL load_w16: got %h want 0053", q16a); end
        ch = 2'b01; d = 1'b1; bits = 16'h0000;
        repeat (3) tick();
        vec++; if (q7a !== 7'h1F) begin errs++; $display("FAIL shup_w7: got %h want 1f", q7a); end
        vec++; if (q16a !== 16'h029F) begin errs++; $display("FAIL shup_w16: got %h want 029f", q16a); end
        vec++; if ({uf[0], pf[0]} !== 2'b01) begin errs++; $display("FAIL flips_w7: got %b want 01", {uf[0], pf[0]}); end
        ch = 2'b00; d = 1'b0;
        tick();
        vec++; if (q7a !== 7'h1F || q16a !== 16'h029F) begin errs++; $display("FAIL hold: got %h/%h want 1f/029f", q7a, q16a); end
        en = 1'b0; ch = 2'b11; bits = 16'hAAAA;
        tick();
        vec++; if (q7a !== 7'h1F || q16a !== 16'h029F) begin errs++; $display("FAIL en_low: got %h/%h want 1f/029f", q7a, q16a); end
        en = 1'b1; ch = 2'b10; d_esq = 1'b1;
        tick();
        vec++; if (q7a !== 7'h4F) begin errs++; $display("FAIL shdn_w7: got %h want 4f", q7a); end
        vec++; if (q16a !== 16'h814F) begin errs++; $display("FAIL shdn_w16: got %h want 814f", q16a); end
        vec++; if ({uf[2], pf[2]} !== 2'b11) begin errs++; $display("FAIL flips_w16: got %b want 11", {uf[2], pf[2]}); end
        ch = 2'b00; d_esq = 1'b0;
    endtask

    task automatic test_rotate();
        ch = 2'b11; bits = 16'h0041;
        tick();
        ch = 2'b10;
        tick();
        vec++; if (q7b !== 7'h60) begin errs++; $display("FAIL rotdn_w7: got %h want 60", q7b); end
        vec++; if (q16b !== 16'h8020) begin errs++; $display("FAIL rotdn_w16: got %h want 8020", q16b); end
        ch = 2'b01;
        repeat (2) tick();
        vec++; if (q7b !== 7'h03) begin errs++; $display("FAIL rotup_w7: got %h want 03", q7b); end
        vec++; if (q16b !== 16'h0082) begin errs++; $display("FAIL rotup_w16: got %h want 0082", q16b); end
        ch = 2'b00;
    endtask

    task automatic test_burst();
        start = 1'b1; bits = 16'h0005; n_shifts = 5'd3; d = 1'b0;
        tick();
        start = 1'b0; ch = 2'b11; bits = 16'h007F;
        vec++; if (bsy[0] !== 1'b1 || bsy[2] !== 1'b1 || dn[0] !== 1'b0) begin errs++; $display("FAIL burst_busy: busy %b done %b want x1x1 / 0", bsy, dn); end
        vec++; if (q7a !== 7'h05 || q16a !== 16'h0005) begin errs++; $display("FAIL burst_load: got %h/%h want 05/0005", q7a, q16a); end
        repeat (2) tick();
        vec++; if (q7a !== 7'h14 || dn[0] !== 1'b0 || bsy[0] !== 1'b1) begin errs++; $display("FAIL burst_mid: q %h done %b busy %b want 14/0/1", q7a, dn[0], bsy[0]); end
        ch = 2'b10;
        tick();
        vec++; if (q7a !== 7'h28 || q16a !== 16'h0028) begin errs++; $display("FAIL burst_q: got %h/%h want 28/0028", q7a, q16a); end
        vec++; if (dn[0] !== 1'b1 || dn[2] !== 1'b1 || bsy[0] !== 1'b1) begin errs++; $display("FAIL burst_done: done %b busy %b want done=1 busy=1", dn, bsy); end
        ch = 2'b00; start = 1'b1; bits = 16'h0000;
        tick();
        start = 1'b0;
        vec++; if (dn[0] !== 1'b0 || bsy[0] !== 1'b0 || dn[2] !== 1'b0 || bsy[2] !== 1'b0) begin errs++; $display("FAIL burst_idle: done %b busy %b want 0/0", dn, bsy); end
        vec++; if (q7a !== 7'h28 || q16a !== 16'h0028) begin errs++; $display("FAIL burst_holdq: got %h/%h want 28/0028", q7a, q16a); end
        tick();
        vec++; if (bsy[0] !== 1'b0 || q7a !== 7'h28) begin errs++; $display("FAIL start_in_done: busy %b q %h want 0/28", bsy[0], q7a); end
    endtask

    task automatic test_zero_and_full();
        start = 1'b1; bits = 16'h0033; n_shifts = 5'd0;
        tick();
        start = 1'b0;
        vec++; if (q7a !== 7'h33 || dn[0] !== 1'b1 || bsy[0] !== 1'b1) begin errs++; $display("FAIL zero_w7: q %h done %b busy %b want 33/1/1", q7a, dn[0], bsy[0]); end
        vec++; if (q16a !== 16'h0033 || dn[2] !== 1'b1) begin errs++; $display("FAIL zero_w16: q %h done %b want 0033/1", q16a, dn[2]); end
        tick();
        vec++; if (dn[0] !== 1'b0 || bsy[0] !== 1'b0 || dn[2] !== 1'b0) begin errs++; $display("FAIL zero_end: done %b busy %b want 0/0", dn, bsy); end
        start = 1'b1; bits = 16'h0000; n_shifts = 5'd7; d = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        vec++; if (dn[0] !== 1'b0 || q7a !== 7'h3F) begin errs++; $display("FAIL full_pre: done %b q %h want 0/3f", dn[0], q7a); end
        tick();
        vec++; if (q7a !== 7'h7F || q16a !== 16'h007F || dn[0] !== 1'b1) begin errs++; $display("FAIL full: q %h/%h done %b want 7f/007f/1", q7a, q16a, dn[0]); end
        d = 1'b0;
        tick();
    endtask

    task automatic test_en_pause();
        start = 1'b1; bits = 16'h0001; n_shifts = 5'd3; d = 1'b0;
        tick();
        start = 1'b0;
        tick();
        en = 1'b0;
        repeat (2) tick();
        vec++; if (q7a !== 7'h02 || bsy[0] !== 1'b1 || dn[0] !== 1'b0) begin errs++; $display("FAIL pause: q %h busy %b done %b want 02/1/0", q7a, bsy[0], dn[0]); end
        en = 1'b1;
        tick();
        vec++; if (q7a !== 7'h04 || dn[0] !== 1'b0) begin errs++; $display("FAIL resume: q %h done %b want 04/0", q7a, dn[0]); end
        tick();
        vec++; if (q7a !== 7'h08 || q16a !== 16'h0008 || dn[0] !== 1'b1 || dn[2] !== 1'b1) begin errs++; $display("FAIL pause_done: q %h/%h done %b want 08/0008/1", q7a, q16a, dn); end
        en = 1'b0;
        tick();
        vec++; if (bsy[0] !== 1'b0 || dn[0] !== 1'b0 || bsy[2] !== 1'b0) begin errs++; $display("FAIL done_en_low: busy %b done %b want 0/0", bsy, dn); end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; bits = 16'h0003; n_shifts = 5'd4; d = 1'b0;
        tick();
        start = 1'b0;
        repeat (2) tick();
        vec++; if (q7a !== 7'h0C || bsy[0] !== 1'b1) begin errs++; $display("FAIL mid_pre: q %h busy %b want 0c/1", q7a, bsy[0]); end
        rst_n = 1'b0;
        tick();
        vec++; if (q7a !== 7'h00 || q16a !== 16'h0000 || bsy !== 4'h0 || dn !== 4'h0) begin errs++; $display("FAIL mid_reset: q %h/%h busy %b done %b want 0/0/0/0", q7a, q16a, bsy, dn); end
        rst_n = 1'b1; start = 1'b1; bits = 16'h0001; n_shifts = 5'd2;
        tick();
        start = 1'b0;
        vec++; if (q7a !== 7'h01 || bsy[0] !== 1'b1 || dn[0] !== 1'b0) begin errs++; $display("FAIL fresh_start: q %h busy %b done %b want 01/1/0", q7a, bsy[0], dn[0]); end
        tick();
        vec++; if (dn[0] !== 1'b0) begin errs++; $display("FAIL fresh_nodone: done %b want 0", dn[0]); end
        tick();
        vec++; if (q7a !== 7'h04 || q16a !== 16'h0004 || dn[0] !== 1'b1) begin errs++; $display("FAIL fresh_done: q %h/%h done %b want 04/0004/1", q7a, q16a, dn[0]); end
        tick();
    endtask

    task automatic test_clamp();
        int k;
        k = 0;
        start = 1'b1; bits = 16'h0000; n_shifts = 5'd20; d = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (dn[2] === 1'b1) begin
                k = i;
                break;
            end
        end
        vec++; if (k !== 16) begin errs++; $display("FAIL clamp_len: got %0d shifts want 16", k); end
        vec++; if (q16a !== 16'hFFFF) begin errs++; $display("FAIL clamp_q: got %h want ffff", q16a); end
        d = 1'b0;
        tick();
        vec++; if (bsy[2] !== 1'b0) begin errs++; $display("FAIL clamp_idle: busy %b want 0", bsy[2]); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ch = 2'b00; d = 1'b0; d_esq = 1'b0;
        start = 1'b0; bits = 16'h0000; n_shifts = 5'd0;
        test_reset();
        test_manual();
        test_rotate();
        test_burst();
        test_zero_and_full();
        test_en_pause();
        test_reset_mid();
        test_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/registrador_universal.md
REGISTRADOR_UNIVERSAL -- requirements
Module: registrador_universal

Interface
REQ-001 SHALL have parameter WIDTH, default 7, register length in bits (legal range 2..32).
REQ-002 SHALL have parameter ROTATE, default 0; 1 = serial input of each shift taken from the bit leaving the opposite end (rotate).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  clock enable; 0 = all state (register, counter, FSM) frozen.
REQ-006 SHALL have port ch  input  2  manual mode: 00 hold, 01 shift up, 10 shift down, 11 parallel load.
REQ-007 SHALL have port d  input  1  serial input entering q[0] on shift up.
REQ-008 SHALL have port d_esq  input  1  serial input entering q[WIDTH-1] on shift down.
REQ-009 SHALL have port bits  input  WIDTH  parallel load data.
REQ-010 SHALL have port start  input  1  request automatic load-and-shift burst.
REQ-011 SHALL have port n_shifts  input  clog2(WIDTH+1)  burst length in shifts.
REQ-012 SHALL have port saidas_registrador  output  WIDTH  register contents q.
REQ-013 SHALL have port saida_ultimoflip  output  1  q[WIDTH-1].
REQ-014 SHALL have port saida_primeiroflip  output  1  q[0].
REQ-015 SHALL have port busy  output  1  burst in progress.
REQ-016 SHALL have port done  output  1  one-cycle burst completion pulse.

Function
REQ-017 Shift up SHALL do q[0]<=d (ROTATE=1: q[WIDTH-1]), q[i]<=q[i-1] for i>=1.
REQ-018 Shift down SHALL do q[WIDTH-1]<=d_esq (ROTATE=1: q[0]), q[i]<=q[i+1] for i<WIDTH-1.
REQ-019 Parallel load SHALL do q<=bits; hold SHALL leave q unchanged.
REQ-020 FSM SHALL have states IDLE, SHIFT, DONE; all outputs registered, no combinational input-to-output path.
REQ-021 IDLE: en=1 and start=0 SHALL apply ch mode per REQ-017..019.
REQ-022 IDLE: en=1 and start=1 SHALL override ch, load q<=bits, load counter with min(n_shifts, WIDTH), go SHIFT; if that value is 0, go DONE instead.
REQ-023 SHIFT: each en=1 cycle SHALL shift up (REQ-017) and decrement counter; shift with counter==1 SHALL go DONE.
REQ-024 SHIFT: ch and start SHALL be ignored; en=0 SHALL pause without losing count.
REQ-025 DONE: done=1 for exactly that cycle, q held, next cycle IDLE regardless of en; start in DONE SHALL be ignored.
REQ-026 busy SHALL be 1 in SHIFT and DONE states, 0 in IDLE.
REQ-027 Burst of N shifts SHALL take N+1 enabled cycles from start sample to DONE entry; done visible one cycle after last shift.
REQ-028 n_shifts > WIDTH SHALL be clamped to WIDTH (register fully flushed with d).

Reset
REQ-029 rst_n=0 at a rising edge SHALL force q=0, counter=0, state IDLE, busy=0, done=0, overriding en, start, ch.
REQ-030 Reset mid-burst SHALL abort burst with no done pulse; first post-reset cycle behaves as IDLE.
REQ-031 Between reset and first clock outputs SHALL be undefined; bench checks only after first edge with rst_n=0.

Verification
REQ-032 WIDTH=7: reset; ch=11, bits=1010011 -> q=1010011; ch=01, d=1, 3 cycles -> q=0011111 (q[6..0]).
REQ-033 WIDTH=7, ROTATE=1: load 1000001, ch=10 one cycle -> q=1100000; ch=01 two cycles -> q=0000011.
REQ-034 WIDTH=7: start=1, bits=0000101, n_shifts=3, d=0 -> busy next cycle, q=0101000 after 3 shifts, done pulse 1 cycle, then IDLE; ch changes during burst ignored.
REQ-035 Burst n_shifts=0 -> load only, DONE next cycle, done one cycle; n_shifts=7 with d=1 -> q=1111111; en toggled low mid-burst stretches busy by exact number of low cycles.
REQ-036 Reset asserted during SHIFT with 2 shifts left -> q=0, busy=0, no done pulse; start next cycle begins fresh burst.
REQ-037 WIDTH=16 regression of REQ-032..036 patterns, zero-extended, same cycle counts.
